uart_transmitter: RTL and testbench

- 8N1 UART transmitter with a small internal FIFO. It serialises bytes produced by on-chip logic (LED-matrix status and echo data) onto the tx line.
- It is the sending counterpart of the matrix's UART receive path and uses the same baud derivation, so the two ends interoperate on one link.
- Upstream writes bytes with a valid/ready handshake. The block buffers them and transmits them back to back.

---
 rtl/uart_transmitter_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_transmitter.sv | 130 +++++++++++++
 tb/tb_uart_transmitter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_transmitter_pkg.sv
// Shared UART constants and transmitter FSM encodings, common to the TX and RX ends.
package uart_transmitter_pkg;
  localparam int UART_DATA_BITS    = 8;
  localparam int UART_DEFAULT_BAUD = 115200;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Counter width that stays legal when the divisor collapses to 1.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous circular-buffer FIFO with first-word fall-through read data.
module uart_tx_fifo
  import uart_transmitter_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == (PTR_W+1)'(DEPTH));
  assign empty     = (count_r == {(PTR_W+1){1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: byte FIFO in front of a start/data/stop serialiser.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = UART_DEFAULT_BAUD,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int              BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int              CNT_W      = cnt_width(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BIT_CYCLES - 1);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             tx_r;
  logic [7:0]       fifo_dout_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             push_s;
  logic             pop_s;
  logic             bit_done_s;

  assign tx_ready   = !fifo_full_s;
  assign push_s     = tx_valid && !fifo_full_s;
  assign bit_done_s = (cnt_r == {CNT_W{1'b0}});
  assign tx         = tx_r;
  assign tx_busy    = (state_r != ST_IDLE);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   (tx_data),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count)
  );

  // Pop when a new frame can begin: from idle, or at the end of a stop bit.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_IDLE: pop_s = !fifo_empty_s;
      ST_STOP: pop_s = bit_done_s && !fifo_empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Frame sequencer and bit timer; tx is registered so the line never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_r <= 1'b1;
          if (pop_s) begin
            shift_r <= fifo_dout_s;
            tx_r    <= 1'b0;
            cnt_r   <= CNT_LOAD;
            state_r <= ST_START;
          end
        end
        ST_START: begin
          if (bit_done_s) begin
            tx_r      <= shift_r[0];
            bit_idx_r <= 3'd0;
            cnt_r     <= CNT_LOAD;
            state_r   <= ST_DATA;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_done_s) begin
            cnt_r <= CNT_LOAD;
            if (bit_idx_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= ST_STOP;
            end else begin
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_done_s) begin
            if (pop_s) begin
              shift_r <= fifo_dout_s;
              tx_r    <= 1'b0;
              cnt_r   <= CNT_LOAD;
              state_r <= ST_START;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          tx_r    <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: small-divisor instance plus a default-parameter smoke instance.
module tb_uart_transmitter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, tx_busy;
  logic [4:0] fifo_count;

  logic [7:0] d_data = 8'h00;
  logic       d_valid = 1'b0;
  logic       d_ready, d_tx, d_busy;
  logic [4:0] d_count;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [7:0] byte_q[$];
  logic       stop_q[$];
  int         t_q[$];

  uart_transmitter #(.CLK_FREQ(80), .BAUD_RATE(10), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  uart_transmitter u_def (
    .clk(clk), .rst_n(rst_n), .tx_data(d_data), .tx_valid(d_valid),
    .tx_ready(d_ready), .tx(d_tx), .tx_busy(d_busy), .fifo_count(d_count)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference receiver for 8-cycle bits: detect start, sample mid-bit, record stop level and start time.
  initial begin : monitor
    logic [7:0] b;
    logic       st;
    int         t0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        t0 = cyc;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (8) @(negedge clk);
          b[i] = tx;
        end
        repeat (8) @(negedge clk);
        st = tx;
        byte_q.push_back(b);
        stop_q.push_back(st);
        t_q.push_back(t0);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_q();
    byte_q.delete();
    stop_q.delete();
    t_q.delete();
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((tx_busy !== 1'b0 || fifo_count !== 5'd0) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", 32'(tx_busy === 1'b0 && fifo_count === 5'd0), 32'd1);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (byte_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin : stim
    logic [9:0] f;
    logic       e;
    int         errs;
    int         busy_n;
    int         k;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single byte 0xA5, exact waveform and busy length
    clear_q();
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("t1_accept_tx", 32'(tx), 32'd1);
    check("t1_accept_count", 32'(fifo_count), 32'd1);
    f = {1'b1, 8'hA5, 1'b0};
    errs = 0; busy_n = 0;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      e = (i < 80) ? f[i / 8] : 1'b1;
      if (tx !== e) errs++;
      if (tx_busy === 1'b1) busy_n++;
    end
    check("t1_wave_errs", 32'(errs), 32'd0);
    check("t1_busy_cycles", 32'(busy_n), 32'd80);

    // 2: burst of three bytes, back-to-back frames
    wait_idle(); clear_q();
    tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge clk); tx_data = 8'hFF;
    @(negedge clk); tx_data = 8'h55;
    @(negedge clk); tx_valid = 1'b0;
    wait_frames(3, 400);
    check("t2_frames", 32'(byte_q.size()), 32'd3);
    if (byte_q.size() >= 3) begin
      check("t2_byte0", 32'(byte_q[0]), 32'h00);
      check("t2_byte1", 32'(byte_q[1]), 32'hFF);
      check("t2_byte2", 32'(byte_q[2]), 32'h55);
      check("t2_stops", 32'({stop_q[0], stop_q[1], stop_q[2]}), 32'h7);
      check("t2_gap01", 32'(t_q[1] - t_q[0]), 32'd80);
      check("t2_gap12", 32'(t_q[2] - t_q[1]), 32'd80);
    end

    // 3: seventeen writes fill the FIFO while the first byte is in flight
    wait_idle(); clear_q();
    errs = 0;
    for (int i = 0; i < 17; i++) begin
      tx_data = 8'h10 + 8'(i); tx_valid = 1'b1;
      if (tx_ready !== 1'b1) errs++;
      @(negedge clk);
    end
    check("t3_ready_during_fill", 32'(errs), 32'd0);
    check("t3_full_count", 32'(fifo_count), 32'd16);
    check("t3_full_ready", 32'(tx_ready), 32'd0);
    tx_data = 8'h21;
    repeat (10) @(negedge clk);
    check("t3_stall_count", 32'(fifo_count), 32'd16);

    // 4: pop at STOP->START frees one slot for one cycle, then the held byte is taken
    k = 0;
    while (tx_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t4_ready_rises", 32'(tx_ready), 32'd1);
    check("t4_count_after_pop", 32'(fifo_count), 32'd15);
    @(negedge clk);
    tx_valid = 1'b0;
    check("t4_count_after_push", 32'(fifo_count), 32'd16);
    check("t4_ready_falls", 32'(tx_ready), 32'd0);
    wait_frames(18, 1700);
    check("t3_frames", 32'(byte_q.size()), 32'd18);
    errs = 0;
    for (int i = 0; i < byte_q.size() && i < 18; i++)
      if (byte_q[i] !== 8'h10 + 8'(i) || stop_q[i] !== 1'b1) errs++;
    check("t3_order", 32'(errs), 32'd0);

    // 5: reset in the middle of a data bit, then a clean frame
    wait_idle(); clear_q();
    tx_data = 8'h3C; tx_valid = 1'b1;
    repeat (2) @(negedge clk);
    tx_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_pre_count", 32'(fifo_count), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_tx", 32'(tx), 32'd1);
    check("t5_rst_busy", 32'(tx_busy), 32'd0);
    check("t5_rst_count", 32'(fifo_count), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("t5_post_idle_tx", 32'(tx), 32'd1);
    clear_q();
    tx_data = 8'h81; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_frames(1, 200);
    repeat (20) @(negedge clk);
    check("t5_frames", 32'(byte_q.size()), 32'd1);
    if (byte_q.size() >= 1) check("t5_byte", 32'(byte_q[0]), 32'h81);

    // 6: all 256 byte values through the reference receiver
    wait_idle(); clear_q();
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      tx_data = 8'(i); tx_valid = 1'b1;
      k = 0;
      while (tx_ready !== 1'b1 && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (k >= 200) errs++;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("t6_push_timeouts", 32'(errs), 32'd0);
    wait_frames(256, 2000);
    repeat (20) @(negedge clk);
    check("t6_frames", 32'(byte_q.size()), 32'd256);
    errs = 0;
    for (int i = 0; i < byte_q.size() && i < 256; i++)
      if (byte_q[i] !== 8'(i) || stop_q[i] !== 1'b1) errs++;
    check("t6_bytes", 32'(errs), 32'd0);

    // Smoke: default parameters, 434-cycle bits, byte 0x5A
    d_data = 8'h5A; d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    f = {1'b1, 8'h5A, 1'b0};
    errs = 0; busy_n = 0;
    for (int i = 0; i < 4400; i++) begin
      @(negedge clk);
      e = (i < 4340) ? f[i / 434] : 1'b1;
      if (d_tx !== e) errs++;
      if (d_busy === 1'b1) busy_n++;
    end
    check("def_wave_errs", 32'(errs), 32'd0);
    check("def_busy_cycles", 32'(busy_n), 32'd4340);
    check("def_count", 32'(d_count), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
